// File: rtl/uart_vector_tx_ctrl.sv
// Streams a block of memory words out through a byte-wide UART transmitter.
// Each word is read once, then split into bytes and handed over with a start/busy handshake.
module uart_vector_tx_ctrl #(
    parameter int unsigned WordBytes = 4,
    parameter int unsigned AddrWidth = 10,
    parameter bit          LsbFirst  = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic [AddrWidth-1:0]   length_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mem_en_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    input  logic [8*WordBytes-1:0] mem_rdata_i,
    output logic                   tx_start_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_busy_i
);

    localparam int unsigned DataWidth = 8 * WordBytes;
    localparam int unsigned IdxWidth  = (WordBytes > 1) ? $clog2(WordBytes) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(WordBytes - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StSend,
        StWaitHi,
        StWaitLo,
        StDone
    } state_e;

    state_e               state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth-1:0] cnt_q;
    logic [IdxWidth-1:0]  idx_q;
    logic [DataWidth-1:0] word_q;
    logic [7:0]           tx_data_q;

    function automatic logic [7:0] pick_byte(input logic [DataWidth-1:0] word,
                                             input logic [IdxWidth-1:0]  idx);
        int unsigned          pos;
        logic [DataWidth-1:0] shifted;
        pos     = LsbFirst ? 32'(idx) : (WordBytes - 32'd1 - 32'(idx));
        shifted = word >> (8 * pos);
        return shifted[7:0];
    endfunction

    // tx_data is loaded on entry to SEND so it is stable during the tx_start pulse
    // and holds the sent byte until the next one is queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            tx_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (length_i != '0) begin
                            addr_q  <= base_addr_i;
                            cnt_q   <= length_i;
                            state_q <= StRead;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StRead: state_q <= StLatch;
                StLatch: begin
                    word_q    <= mem_rdata_i;
                    idx_q     <= '0;
                    tx_data_q <= pick_byte(mem_rdata_i, '0);
                    state_q   <= StSend;
                end
                StSend: begin
                    if (!tx_busy_i) state_q <= StWaitHi;
                end
                StWaitHi: begin
                    if (tx_busy_i) state_q <= StWaitLo;
                end
                StWaitLo: begin
                    if (!tx_busy_i) begin
                        if (idx_q != LastIdx) begin
                            idx_q     <= idx_q + 1'b1;
                            tx_data_q <= pick_byte(word_q, idx_q + 1'b1);
                            state_q   <= StSend;
                        end else if (cnt_q > AddrWidth'(1)) begin
                            cnt_q   <= cnt_q - 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            state_q <= StRead;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_en_o   = (state_q == StRead);
    assign mem_addr_o = addr_q;
    assign done_o     = (state_q == StDone);
    assign busy_o     = (state_q == StRead) || (state_q == StLatch) || (state_q == StSend) ||
                        (state_q == StWaitHi) || (state_q == StWaitLo);
    assign tx_start_o = (state_q == StSend) && !tx_busy_i;
    assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_vector_tx_ctrl.sv
// Bench for uart_vector_tx_ctrl: two instances (LSB-first and MSB-first) share stimulus and memory;
// expected reads/bytes are queued at issue time and popped by per-instance monitors.
module tb_uart_vector_tx_ctrl;

    localparam int AW      = 10;
    localparam int WB      = 4;
    localparam int DW      = 8 * WB;
    localparam int BusyLen = 6;

    typedef logic [AW-1:0] addr_t;
    typedef logic [7:0]    byte_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    addr_t base, len;

    logic          busy     [2];
    logic          done     [2];
    logic          mem_en   [2];
    logic          tx_start [2];
    logic          tx_busy  [2];
    addr_t         mem_addr [2];
    logic [DW-1:0] rdata    [2];
    byte_t         tx_data  [2];

    logic [DW-1:0] mem [1 << AW];

    addr_t exp_addr [2][$];
    byte_t exp_byte [2][$];
    int unsigned exp_done;
    int unsigned done_cnt [2];
    int unsigned tx_cnt   [2];

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RiseDly = 2 * g;
        int busy_c = 0;
        int dly_c  = 0;

        uart_vector_tx_ctrl #(
            .WordBytes (WB),
            .AddrWidth (AW),
            .LsbFirst  (g == 0)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .start_i     (start),
            .base_addr_i (base),
            .length_i    (len),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .mem_en_o    (mem_en[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_rdata_i (rdata[g]),
            .tx_start_o  (tx_start[g]),
            .tx_data_o   (tx_data[g]),
            .tx_busy_i   (tx_busy[g])
        );

        always @(posedge clk) if (mem_en[g]) rdata[g] <= mem[mem_addr[g]];

        // UART model: unaffected by the controller reset; instance 1 raises busy late.
        always @(posedge clk) begin
            if (busy_c > 0) busy_c <= busy_c - 1;
            if (tx_start[g]) begin
                if (RiseDly == 0) busy_c <= BusyLen;
                else dly_c <= RiseDly;
            end else if (dly_c > 0) begin
                dly_c <= dly_c - 1;
                if (dly_c == 1) busy_c <= BusyLen;
            end
        end
        assign tx_busy[g] = (busy_c != 0);

        always @(negedge clk) begin
            if (rst_n) begin
                if (mem_en[g]) begin
                    chk($sformatf("dut%0d busy during read", g), 64'(busy[g]), 64'd1);
                    if (exp_addr[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dut%0d read: got unexpected read at 0x%0h expected none",
                                 g, mem_addr[g]);
                    end else begin
                        chk($sformatf("dut%0d read addr", g), 64'(mem_addr[g]),
                            64'(exp_addr[g].pop_front()));
                    end
                end
                if (tx_start[g]) begin
                    tx_cnt[g]++;
                    chk($sformatf("dut%0d busy during tx", g), 64'(busy[g]), 64'd1);
                    if (exp_byte[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dut%0d tx byte: got unexpected byte 0x%0h expected none",
                                 g, tx_data[g]);
                    end else begin
                        chk($sformatf("dut%0d tx byte", g), 64'(tx_data[g]),
                            64'(exp_byte[g].pop_front()));
                    end
                end
                if (done[g]) done_cnt[g]++;
            end
        end
    end

    task automatic push_xfer(input addr_t b, input int n, input bit completes);
        for (int i = 0; i < n; i++) begin
            addr_t         a;
            logic [DW-1:0] w;
            a = b + AW'(i);
            w = mem[a];
            exp_addr[0].push_back(a);
            exp_addr[1].push_back(a);
            for (int j = 0; j < WB; j++) begin
                exp_byte[0].push_back(w[8*j +: 8]);
                exp_byte[1].push_back(w[8*(WB-1-j) +: 8]);
            end
        end
        if (completes) exp_done++;
    endtask

    task automatic pulse_start(input addr_t b, input addr_t n);
        @(posedge clk);
        #1 start = 1'b1; base = b; len = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 3000 && !(done_cnt[0] == exp_done && done_cnt[1] == exp_done); c++)
            @(posedge clk);
        repeat (12) @(posedge clk);
        chk({name, " dut0 done count"}, 64'(done_cnt[0]), 64'(exp_done));
        chk({name, " dut1 done count"}, 64'(done_cnt[1]), 64'(exp_done));
        chk({name, " dut0 bytes left"}, 64'(exp_byte[0].size()), 64'd0);
        chk({name, " dut1 bytes left"}, 64'(exp_byte[1].size()), 64'd0);
        chk({name, " reads left"}, 64'(exp_addr[0].size() + exp_addr[1].size()), 64'd0);
    endtask

    task automatic wait_tx(input int unsigned target);
        for (int c = 0; c < 2000 && tx_cnt[0] < target; c++) @(posedge clk);
        chk("reach byte", 64'(tx_cnt[0]), 64'(target));
    endtask

    initial begin
        int unsigned t0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10'h005] = 32'hA1B2C3D4;
        mem[10'h3FE] = 32'h11223344;
        mem[10'h3FF] = 32'h55667788;
        mem[10'h000] = 32'h99AABBCC;
        mem[10'h020] = 32'h01020304;
        mem[10'h021] = 32'hF0E1D2C3;
        mem[10'h100] = 32'hDEADBEEF;
        mem[10'h007] = 32'hCAFEF00D;
        mem[10'h030] = 32'h13579BDF;
        mem[10'h031] = 32'h2468ACE0;
        exp_done = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        tx_cnt[0] = 0;   tx_cnt[1] = 0;
        start = 1'b0; base = '0; len = '0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(busy[0]), 64'd0);
        chk("reset done", 64'(done[0]), 64'd0);
        chk("reset mem_en", 64'(mem_en[0]), 64'd0);
        chk("reset tx_start", 64'(tx_start[0]), 64'd0);
        chk("reset mem_addr", 64'(mem_addr[0]), 64'd0);
        chk("reset tx_data", 64'(tx_data[0]), 64'd0);

        // Single word with start-to-tx latency.
        push_xfer(10'h005, 1, 1'b1);
        pulse_start(10'h005, 10'd1);
        @(negedge clk);
        chk("latency cycle1 mem_en", 64'(mem_en[0]), 64'd1);
        @(negedge clk);
        chk("latency cycle2 mem_en", 64'(mem_en[0]), 64'd0);
        @(negedge clk);
        chk("latency cycle3 tx_start", 64'(tx_start[0]), 64'd1);
        wait_done("single");

        push_xfer(10'h3FE, 3, 1'b1);
        pulse_start(10'h3FE, 10'd3);
        wait_done("wrap");

        exp_done++;
        pulse_start(10'h010, 10'd0);
        @(negedge clk);
        chk("zero len done", 64'(done[0]), 64'd1);
        chk("zero len dut1 done", 64'(done[1]), 64'd1);
        chk("zero len busy", 64'(busy[0]), 64'd0);
        wait_done("zero");

        // A start during the second byte must be ignored.
        t0 = tx_cnt[0];
        push_xfer(10'h020, 2, 1'b1);
        pulse_start(10'h020, 10'd2);
        wait_tx(t0 + 2);
        #1 start = 1'b1; base = 10'h100; len = 10'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignored start");

        push_xfer(10'h007, 1, 1'b1);
        pulse_start(10'h007, 10'd1);
        wait_done("after done");

        // Reset in WAIT_HI of byte 2.
        t0 = tx_cnt[0];
        push_xfer(10'h030, 1, 1'b0);
        pulse_start(10'h030, 10'd1);
        wait_tx(t0 + 2);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy[0]), 64'd0);
        chk("midreset dut1 busy", 64'(busy[1]), 64'd0);
        chk("midreset mem_addr", 64'(mem_addr[0]), 64'd0);
        chk("midreset tx_data", 64'(tx_data[0]), 64'd0);
        chk("midreset tx_start", 64'(tx_start[0]), 64'd0);
        chk("midreset done", 64'(done[0]), 64'd0);
        exp_addr[0].delete(); exp_addr[1].delete();
        exp_byte[0].delete(); exp_byte[1].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 200 && (tx_busy[0] || tx_busy[1]); c++) @(posedge clk);
        chk("uart idle after reset", 64'(tx_busy[0] | tx_busy[1]), 64'd0);
        t0 = tx_cnt[0];
        push_xfer(10'h031, 1, 1'b1);
        pulse_start(10'h031, 10'd1);
        wait_done("post reset");
        chk("post reset byte count", 64'(tx_cnt[0] - t0), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
